// File: rtl/spi_flash_sequencer_if.sv
// Byte-shifter bus between the flash command sequencer and the SPI byte shifter.
// The sequencer is the master: it frames commands with chip_select and launches bytes.
interface spi_flash_sequencer_if;
    logic       chip_select;
    logic       byte_start;
    logic [7:0] byte_tx;
    logic       byte_done;
    logic [7:0] byte_rx;

    modport master (
        output chip_select,
        output byte_start,
        output byte_tx,
        input  byte_done,
        input  byte_rx
    );

    modport slave (
        input  chip_select,
        input  byte_start,
        input  byte_tx,
        output byte_done,
        output byte_rx
    );
endinterface

// File: rtl/spi_flash_sequencer.sv
// Round-robin command sequencer for two requesters sharing one M25P16 flash:
// opcode, optional 24-bit address, then N read bytes, one byte outstanding at a time.
module spi_flash_sequencer #(
    parameter int LEN_W       = 8,
    parameter int CS_IDLE_CYC = 4
) (
    input  logic             cclk_i,
    input  logic             reset_i,
    input  logic [1:0]       req_i,
    input  logic [7:0]       opcode0_i,
    input  logic [7:0]       opcode1_i,
    input  logic [23:0]      addr0_i,
    input  logic [23:0]      addr1_i,
    input  logic             use_addr0_i,
    input  logic             use_addr1_i,
    input  logic [LEN_W-1:0] rd_len0_i,
    input  logic [LEN_W-1:0] rd_len1_i,
    output logic [1:0]       grant_o,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    output logic [1:0]       done_o,
    spi_flash_sequencer_if.master flash_if
);

    localparam int CNT_W = $clog2(CS_IDLE_CYC + 1);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(CS_IDLE_CYC);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_OPC  = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_READ = 3'd3;
    localparam logic [2:0] ST_END  = 3'd4;
    localparam logic [2:0] ST_GAP  = 3'd5;

    logic [2:0]       state_q,    state_d;
    logic [1:0]       grant_q,    grant_d;
    logic [1:0]       done_q,     done_d;
    logic [7:0]       rx_data_q,  rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             cs_q,       cs_d;
    logic             start_q,    start_d;
    logic [7:0]       tx_q,       tx_d;
    logic             busy_q,     busy_d;
    logic             last_q,     last_d;
    logic             win_q,      win_d;
    logic [CNT_W-1:0] idle_q,     idle_d;
    logic [23:0]      addr_q,     addr_d;
    logic             use_addr_q, use_addr_d;
    logic [LEN_W-1:0] len_q,      len_d;
    logic [LEN_W-1:0] cnt_q,      cnt_d;
    logic [1:0]       aidx_q,     aidx_d;

    logic             byte_ev_s;
    logic             win_s;
    logic             issue_s;
    logic [7:0]       issue_byte_s;
    logic             finish_s;

    assign grant_o              = grant_q;
    assign done_o               = done_q;
    assign rx_data_o            = rx_data_q;
    assign rx_valid_o           = rx_valid_q;
    assign flash_if.chip_select = cs_q;
    assign flash_if.byte_start  = start_q;
    assign flash_if.byte_tx     = tx_q;

    // Next-state logic: arbitration, byte sequencing and command completion.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        done_d       = 2'b00;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        cs_d         = cs_q;
        start_d      = 1'b0;
        tx_d         = tx_q;
        busy_d       = busy_q;
        last_d       = last_q;
        win_d        = win_q;
        idle_d       = idle_q;
        addr_d       = addr_q;
        use_addr_d   = use_addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        aidx_d       = aidx_q;
        issue_s      = 1'b0;
        issue_byte_s = 8'h00;
        finish_s     = 1'b0;

        // A done pulse only counts against a byte that is actually in flight.
        byte_ev_s = busy_q & flash_if.byte_done;

        case (req_i)
            2'b01:   win_s = 1'b0;
            2'b10:   win_s = 1'b1;
            2'b11:   win_s = ~last_q;
            default: win_s = 1'b0;
        endcase

        if (cs_q && (idle_q < IDLE_MAX)) begin
            idle_d = idle_q + CNT_W'(1);
        end else begin
            idle_d = idle_q;
        end

        if (byte_ev_s) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end

        case (state_q)
            ST_IDLE: begin
                if ((req_i != 2'b00) && (idle_q >= IDLE_MAX)) begin
                    win_d        = win_s;
                    grant_d      = win_s ? 2'b10 : 2'b01;
                    addr_d       = win_s ? addr1_i : addr0_i;
                    use_addr_d   = win_s ? use_addr1_i : use_addr0_i;
                    len_d        = win_s ? rd_len1_i : rd_len0_i;
                    cs_d         = 1'b0;
                    issue_s      = 1'b1;
                    issue_byte_s = win_s ? opcode1_i : opcode0_i;
                    state_d      = ST_OPC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPC: begin
                if (byte_ev_s) begin
                    if (use_addr_q) begin
                        issue_s      = 1'b1;
                        issue_byte_s = addr_q[23:16];
                        aidx_d       = 2'd1;
                        state_d      = ST_ADDR;
                    end else if (len_q != {LEN_W{1'b0}}) begin
                        issue_s = 1'b1;
                        cnt_d   = len_q;
                        state_d = ST_READ;
                    end else begin
                        finish_s = 1'b1;
                    end
                end else begin
                    state_d = ST_OPC;
                end
            end
            ST_ADDR: begin
                if (byte_ev_s) begin
                    if (aidx_q == 2'd1) begin
                        issue_s      = 1'b1;
                        issue_byte_s = addr_q[15:8];
                        aidx_d       = 2'd2;
                    end else if (aidx_q == 2'd2) begin
                        issue_s      = 1'b1;
                        issue_byte_s = addr_q[7:0];
                        aidx_d       = 2'd3;
                    end else if (len_q != {LEN_W{1'b0}}) begin
                        issue_s = 1'b1;
                        cnt_d   = len_q;
                        state_d = ST_READ;
                    end else begin
                        finish_s = 1'b1;
                    end
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_READ: begin
                if (byte_ev_s) begin
                    rx_data_d  = flash_if.byte_rx;
                    rx_valid_d = 1'b1;
                    cnt_d      = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        finish_s = 1'b1;
                    end else begin
                        issue_s = 1'b1;
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_END: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (idle_q >= IDLE_MAX) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue_s) begin
            start_d = 1'b1;
            tx_d    = issue_byte_s;
            busy_d  = 1'b1;
        end else begin
            start_d = 1'b0;
        end

        if (finish_s) begin
            state_d = ST_END;
            cs_d    = 1'b1;
            grant_d = 2'b00;
            done_d  = grant_q;
            last_d  = win_q;
            idle_d  = {CNT_W{1'b0}};
        end else begin
            done_d = 2'b00;
        end
    end

    // State and registered outputs; the idle counter starts saturated so the first request wins at once.
    always_ff @(posedge cclk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            grant_q    <= 2'b00;
            done_q     <= 2'b00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            cs_q       <= 1'b1;
            start_q    <= 1'b0;
            tx_q       <= 8'h00;
            busy_q     <= 1'b0;
            last_q     <= 1'b1;
            win_q      <= 1'b0;
            idle_q     <= IDLE_MAX;
            addr_q     <= 24'h000000;
            use_addr_q <= 1'b0;
            len_q      <= {LEN_W{1'b0}};
            cnt_q      <= {LEN_W{1'b0}};
            aidx_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            cs_q       <= cs_d;
            start_q    <= start_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            last_q     <= last_d;
            win_q      <= win_d;
            idle_q     <= idle_d;
            addr_q     <= addr_d;
            use_addr_q <= use_addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            aidx_q     <= aidx_d;
        end
    end

endmodule

// File: tb/tb_spi_flash_sequencer.sv
// Directed bench for spi_flash_sequencer with a small M25P16/shifter model and
// expected-value queues for byte_tx, rx_data, grant and done.
module tb_spi_flash_sequencer;
    localparam int LEN_W = 8;
    localparam int CS_IDLE_CYC = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req = 2'b00;
    logic [7:0]       opcode0 = 8'h00, opcode1 = 8'h00;
    logic [23:0]      addr0 = 24'h0, addr1 = 24'h0;
    logic             use_addr0 = 1'b0, use_addr1 = 1'b0;
    logic [LEN_W-1:0] rd_len0 = '0, rd_len1 = '0;
    logic [1:0]       grant, done;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             bd_model = 1'b0, bd_stray = 1'b0;
    logic [7:0]       rx_model = 8'h00;

    spi_flash_sequencer_if flash_if ();
    assign flash_if.byte_done = bd_model | bd_stray;
    assign flash_if.byte_rx   = rx_model;

    spi_flash_sequencer #(.LEN_W(LEN_W), .CS_IDLE_CYC(CS_IDLE_CYC)) dut (
        .cclk_i(clk), .reset_i(reset), .req_i(req),
        .opcode0_i(opcode0), .opcode1_i(opcode1), .addr0_i(addr0), .addr1_i(addr1),
        .use_addr0_i(use_addr0), .use_addr1_i(use_addr1), .rd_len0_i(rd_len0), .rd_len1_i(rd_len1),
        .grant_o(grant), .rx_data_o(rx_data), .rx_valid_o(rx_valid), .done_o(done),
        .flash_if(flash_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [1:0] exp_done[$];
    logic [1:0] exp_grant[$];
    int start_cnt = 0, rx_cnt = 0, done_cnt = 0;
    int frame_starts = 0, last_frame = 0, gap = 1000;
    logic cs_prev = 1'b1;
    logic [1:0] grant_prev = 2'b00;
    time last_bd_time = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] resp(input logic [7:0] op, input int idx, input logic [23:0] a);
        if (op == 8'h9F) begin
            case (idx)
                1: return 8'h20;
                2: return 8'h20;
                3: return 8'h15;
                default: return 8'hFF;
            endcase
        end
        if (op == 8'h03 && idx >= 4) begin
            logic [23:0] m;
            m = a + 24'(idx - 4);
            return m[7:0] ^ m[15:8] ^ 8'h5A;
        end
        return 8'hFF;
    endfunction

    // Flash + shifter model: each byte completes two cycles after byte_start.
    int cd = 0, fidx = 0;
    logic [7:0] fop = 8'h00, pend_rx = 8'h00;
    logic [23:0] faddr = 24'h0;
    always @(negedge clk) begin
        if (reset) begin
            cd = 0; bd_model = 1'b0; fidx = 0;
        end else begin
            bd_model = 1'b0;
            if (cd != 0) begin
                cd--;
                if (cd == 0) begin
                    bd_model = 1'b1; rx_model = pend_rx; last_bd_time = $time;
                end
            end
            if (flash_if.chip_select) fidx = 0;
            if (flash_if.byte_start) begin
                if (fidx == 0) fop = flash_if.byte_tx;
                if (fidx >= 1 && fidx <= 3) faddr = {faddr[15:0], flash_if.byte_tx};
                pend_rx = resp(fop, fidx, faddr);
                cd = 2;
                fidx++;
            end
        end
    end

    // Output monitor: scoreboard pops plus per-cycle protocol invariants.
    always @(negedge clk) begin
        if (reset) begin
            gap = 1000;
        end else begin
            chk("grant_not_both", {31'd0, grant == 2'b11}, 32'd0);
            chk("done_not_both", {31'd0, done == 2'b11}, 32'd0);
            chk("cs_low_needs_grant", {31'd0, !flash_if.chip_select && grant == 2'b00}, 32'd0);
            if (grant != 2'b00 && grant_prev == 2'b00) begin
                if (exp_grant.size() == 0) chk("grant_unexpected", {30'd0, grant}, 32'd0);
                else chk("grant_order", {30'd0, grant}, {30'd0, exp_grant.pop_front()});
            end
            if (flash_if.byte_start) begin
                start_cnt++; frame_starts++;
                if (exp_tx.size() == 0) chk("byte_tx_unexpected", {24'd0, flash_if.byte_tx}, 32'hFFFF);
                else chk("byte_tx", {24'd0, flash_if.byte_tx}, {24'd0, exp_tx.pop_front()});
            end
            if (rx_valid) begin
                rx_cnt++;
                if (exp_rx.size() == 0) chk("rx_unexpected", {24'd0, rx_data}, 32'hFFFF);
                else chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
            end
            if (done != 2'b00) begin
                done_cnt++;
                chk("done_latency", 32'($time - last_bd_time), 32'd10);
                chk("grant_clear_at_done", {30'd0, grant}, 32'd0);
                if (exp_done.size() == 0) chk("done_unexpected", {30'd0, done}, 32'd0);
                else chk("done_port", {30'd0, done}, {30'd0, exp_done.pop_front()});
            end
            if (!flash_if.chip_select && cs_prev) begin
                chk("cs_gap_ok", {31'd0, gap >= CS_IDLE_CYC}, 32'd1);
                gap = 0;
            end
            if (flash_if.chip_select) gap++;
            if (flash_if.chip_select && !cs_prev) last_frame = frame_starts;
            if (flash_if.chip_select) frame_starts = 0;
        end
        cs_prev = flash_if.chip_select;
        grant_prev = grant;
    end

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk); n++;
        end
        chk("done_within_budget", {31'd0, done_cnt >= target}, 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_cs"}, {31'd0, flash_if.chip_select}, 32'd1);
        chk({tag, "_grant"}, {30'd0, grant}, 32'd0);
        chk({tag, "_start"}, {31'd0, flash_if.byte_start}, 32'd0);
        chk({tag, "_done"}, {30'd0, done}, 32'd0);
        chk({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    endtask

    task automatic push_rdid();
        opcode0 = 8'h9F; use_addr0 = 1'b0; rd_len0 = 8'd3;
        exp_grant.push_back(2'b01);
        exp_tx.push_back(8'h9F); exp_tx.push_back(8'h00); exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
        exp_rx.push_back(8'h20); exp_rx.push_back(8'h20); exp_rx.push_back(8'h15);
        exp_done.push_back(2'b01);
    endtask

    int base, n;

    initial begin
        // Reset state
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        check_quiet("reset");
        chk("reset_byte_tx", {24'd0, flash_if.byte_tx}, 32'd0);
        chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Stray byte_done in IDLE is ignored
        base = start_cnt;
        bd_stray = 1'b1; @(negedge clk); bd_stray = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("stray");
        chk("stray_no_start", start_cnt, base);

        // RDID on port 0
        push_rdid();
        base = rx_cnt;
        req = 2'b01;
        wait_done(1, 200);
        req = 2'b00;
        @(negedge clk);
        chk("rdid_frame_bytes", last_frame, 32'd4);
        chk("rdid_rx_count", rx_cnt - base, 32'd3);

        // Command only (WREN)
        opcode0 = 8'h06; use_addr0 = 1'b0; rd_len0 = 8'd0;
        exp_grant.push_back(2'b01); exp_tx.push_back(8'h06); exp_done.push_back(2'b01);
        base = rx_cnt;
        req = 2'b01;
        wait_done(2, 200);
        req = 2'b00;
        @(negedge clk);
        chk("wren_frame_bytes", last_frame, 32'd1);
        chk("wren_no_rx", rx_cnt - base, 32'd0);

        // READ on port 1, req dropped after the first data byte
        opcode1 = 8'h03; addr1 = 24'h000100; use_addr1 = 1'b1; rd_len1 = 8'd4;
        exp_grant.push_back(2'b10);
        exp_tx.push_back(8'h03); exp_tx.push_back(8'h00); exp_tx.push_back(8'h01); exp_tx.push_back(8'h00);
        for (int i = 0; i < 4; i++) exp_tx.push_back(8'h00);
        exp_rx.push_back(8'h5B); exp_rx.push_back(8'h5A); exp_rx.push_back(8'h59); exp_rx.push_back(8'h58);
        exp_done.push_back(2'b10);
        base = rx_cnt;
        req = 2'b10;
        n = 0;
        while (rx_cnt < base + 1 && n < 200) begin @(negedge clk); n++; end
        chk("read_first_rx_in_budget", {31'd0, rx_cnt >= base + 1}, 32'd1);
        req = 2'b00;
        wait_done(3, 200);
        @(negedge clk);
        chk("read_frame_bytes", last_frame, 32'd8);
        chk("read_rx_count", rx_cnt - base, 32'd4);

        // Tie right after reset: round-robin 0,1,0,1
        reset = 1'b1; @(negedge clk); @(negedge clk); reset = 1'b0;
        opcode0 = 8'h05; use_addr0 = 1'b0; rd_len0 = 8'd1;
        opcode1 = 8'h06; use_addr1 = 1'b0; rd_len1 = 8'd0;
        for (int k = 0; k < 2; k++) begin
            exp_grant.push_back(2'b01); exp_grant.push_back(2'b10);
            exp_tx.push_back(8'h05); exp_tx.push_back(8'h00); exp_tx.push_back(8'h06);
            exp_rx.push_back(8'hFF);
            exp_done.push_back(2'b01); exp_done.push_back(2'b10);
        end
        base = done_cnt;
        req = 2'b11;
        wait_done(base + 4, 400);
        req = 2'b00;
        repeat (2) @(negedge clk);

        // Reset during the 2nd address byte
        opcode1 = 8'h03; addr1 = 24'h123456; use_addr1 = 1'b1; rd_len1 = 8'd2;
        exp_grant.push_back(2'b10);
        exp_tx.push_back(8'h03); exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
        base = start_cnt;
        req = 2'b10;
        n = 0;
        while (start_cnt < base + 3 && n < 200) begin @(negedge clk); n++; end
        chk("addr2_start_in_budget", {31'd0, start_cnt >= base + 3}, 32'd1);
        reset = 1'b1; req = 2'b00;
        @(negedge clk);
        check_quiet("midreset");
        exp_tx.delete(); exp_rx.delete(); exp_done.delete(); exp_grant.delete();
        @(negedge clk);
        reset = 1'b0;
        base = done_cnt;
        push_rdid();
        req = 2'b01;
        wait_done(base + 1, 200);
        req = 2'b00;
        repeat (2) @(negedge clk);
        chk("post_reset_rdid_frame", last_frame, 32'd4);

        chk("tx_queue_drained", exp_tx.size(), 32'd0);
        chk("rx_queue_drained", exp_rx.size(), 32'd0);
        chk("done_queue_drained", exp_done.size(), 32'd0);
        chk("grant_queue_drained", exp_grant.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
